// File: rtl/pwm_duty_ramper.sv
// Duty-cycle slew source for the PWM generator: steps duty one LSB per step_div periods toward a target.
// Optional triangle "breathe" mode is compiled in with `define PWM_RAMP_BREATHE_EN.
module pwm_duty_ramper #(
  parameter int unsigned DUTY_W = 4,
  parameter int unsigned PERIOD = 16,
  parameter int unsigned DIV_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tgt_valid_i,
  output logic              tgt_ready_o,
  input  logic [DUTY_W-1:0] tgt_duty_i,
  input  logic [DIV_W-1:0]  step_div_i,
`ifdef PWM_RAMP_BREATHE_EN
  input  logic              breathe_en_i,
`endif
  output logic [DUTY_W-1:0] duty_cycle_o,
  output logic              period_tick_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned PCNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  typedef enum logic {S_IDLE, S_RAMP} state_e;

  state_e              state_q, state_d;
  logic [PCNT_W-1:0]   pcnt_q;
  logic [DIV_W-1:0]    scnt_q, scnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DUTY_W-1:0]   tgt_q, tgt_d;
  logic [DUTY_W-1:0]   duty_q, duty_d;
  logic                done_q, done_d;
  logic                down_q, down_d;
  logic                period_tick;
  logic                breathe_act;
  logic [DUTY_W-1:0]   leg_tgt;
  logic [DUTY_W-1:0]   step_duty;

  assign period_tick = (pcnt_q == PCNT_W'(PERIOD - 1));

  // A zero target cannot form a triangle, so breathing is suppressed for it.
`ifdef PWM_RAMP_BREATHE_EN
  assign breathe_act = breathe_en_i && (tgt_q != '0);
`else
  assign breathe_act = 1'b0;
`endif

  // Free-running period counter, aligned with the generator's counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q <= '0;
    end else if (period_tick) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + PCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      scnt_q  <= '0;
      div_q   <= DIV_W'(1);
      tgt_q   <= '0;
      duty_q  <= '0;
      done_q  <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      div_q   <= div_d;
      tgt_q   <= tgt_d;
      duty_q  <= duty_d;
      done_q  <= done_d;
      down_q  <= down_d;
    end
  end

  // Next-state logic; the current leg heads to 0 on a breathe down-leg, else to the latched target.
  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    div_d     = div_q;
    tgt_d     = tgt_q;
    duty_d    = duty_q;
    done_d    = 1'b0;
    down_d    = down_q;
    leg_tgt   = down_q ? '0 : tgt_q;
    step_duty = (duty_q < leg_tgt) ? duty_q + DUTY_W'(1) : duty_q - DUTY_W'(1);

    case (state_q)
      S_IDLE: begin
        if (tgt_valid_i) begin
          tgt_d  = tgt_duty_i;
          div_d  = (step_div_i == '0) ? DIV_W'(1) : step_div_i;
          down_d = 1'b0;
          if (tgt_duty_i == duty_q) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RAMP;
            scnt_d  = '0;
          end
        end
      end
      S_RAMP: begin
        if (period_tick) begin
          if (scnt_q == div_q - DIV_W'(1)) begin
            scnt_d = '0;
            duty_d = step_duty;
            if (step_duty == leg_tgt) begin
              done_d = 1'b1;
              if (breathe_act) begin
                down_d = !down_q;
              end else begin
                state_d = S_IDLE;
                down_d  = 1'b0;
              end
            end
          end else begin
            scnt_d = scnt_q + DIV_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tgt_ready_o   = (state_q == S_IDLE);
  assign busy_o        = (state_q == S_RAMP);
  assign period_tick_o = period_tick;
  assign duty_cycle_o  = duty_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_pwm_duty_ramper.sv
// Bench for pwm_duty_ramper: directed and random targets checked against an arithmetic ramp schedule.
module tb_pwm_duty_ramper;

  localparam int unsigned DUTY_W = 4;
  localparam int unsigned PERIOD = 16;
  localparam int unsigned DIV_W  = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              tgt_valid = 1'b0;
  logic              tgt_ready;
  logic [DUTY_W-1:0] tgt_duty = '0;
  logic [DIV_W-1:0]  step_div = '0;
  logic [DUTY_W-1:0] duty_cycle;
  logic              period_tick;
  logic              busy;
  logic              done;
`ifdef PWM_RAMP_BREATHE_EN
  logic              breathe_en = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  int edges;
  int m_duty   = 0;

  pwm_duty_ramper #(.DUTY_W(DUTY_W), .PERIOD(PERIOD), .DIV_W(DIV_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tgt_valid_i   (tgt_valid),
    .tgt_ready_o   (tgt_ready),
    .tgt_duty_i    (tgt_duty),
    .step_div_i    (step_div),
`ifdef PWM_RAMP_BREATHE_EN
    .breathe_en_i  (breathe_en),
`endif
    .duty_cycle_o  (duty_cycle),
    .period_tick_o (period_tick),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; period boundary edges are those where edges becomes a multiple of PERIOD.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edges <= 0;
    else          edges <= edges + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_duty"},  duty_cycle, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_ready"}, tgt_ready, 1);
  endtask

  // One transfer and the ramp that follows, checked every cycle until the done cycle.
  task automatic do_txn(input int tgt, input int sdiv, input bit hold, input int nxt_tgt, input int nxt_div);
    int div, n, dir, start, e_acc, b, steps;
    div   = (sdiv == 0) ? 1 : sdiv;
    start = m_duty;
    n     = (tgt > start) ? tgt - start : start - tgt;
    dir   = (tgt > start) ? 1 : -1;
    steps = 0;
    tgt_valid = 1'b1;
    tgt_duty  = DUTY_W'(tgt);
    step_div  = DIV_W'(sdiv);
    chk("ready_pre_accept", tgt_ready, 1);
    @(posedge clk); #1;
    e_acc = edges;
    if (hold) begin
      tgt_duty = DUTY_W'(nxt_tgt);
      step_div = DIV_W'(nxt_div);
    end else begin
      tgt_valid = 1'b0;
    end
    for (int c = 0; c < n * div * int'(PERIOD) + int'(PERIOD) + 2; c++) begin
      b = edges / int'(PERIOD) - e_acc / int'(PERIOD);
      steps = b / div;
      if (steps > n) steps = n;
      chk("duty",  duty_cycle, start + dir * steps);
      chk("done",  done, (steps == n) ? 1 : 0);
      chk("busy",  busy, (steps < n) ? 1 : 0);
      chk("ready", tgt_ready, (steps < n) ? 0 : 1);
      chk("tick",  period_tick, ((edges % int'(PERIOD)) == int'(PERIOD) - 1) ? 1 : 0);
      if (steps == n) break;
      @(posedge clk); #1;
    end
    chk("ramp_timeout", steps, n);
    m_duty = tgt;
  endtask

`ifdef PWM_RAMP_BREATHE_EN
  task automatic wait_boundary(input string tag);
    int w;
    w = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while ((edges % int'(PERIOD)) != 0 && w < int'(PERIOD) + 4);
    chk(tag, ((edges % int'(PERIOD)) == 0) ? 1 : 0, 1);
  endtask
`endif

  initial begin
    int t, d;
    // Reset state and tick cadence.
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("in_reset");
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 2 * int'(PERIOD); i++) begin
      @(posedge clk); #1;
      chk("tick_cadence", period_tick, ((edges % int'(PERIOD)) == int'(PERIOD) - 1) ? 1 : 0);
      chk("idle_duty", duty_cycle, 0);
    end

    // Directed ramps: up by 1/period, down with div 3, div 0 to full scale, equal target.
    do_txn(5, 1, 1'b0, 0, 0);
    do_txn(2, 3, 1'b0, 0, 0);
    do_txn(0, 1, 1'b0, 0, 0);
    do_txn(15, 0, 1'b0, 0, 0);
    do_txn(15, 0, 1'b0, 0, 0);
    @(posedge clk); #1;
    chk("sat_hold_duty", duty_cycle, 15);
    chk("eq_no_busy", busy, 0);

    // Valid held through a ramp transfers in the first idle cycle.
    do_txn(10, 1, 1'b1, 7, 2);
    do_txn(7, 2, 1'b0, 0, 0);

    // Randomised targets and dividers.
    for (int k = 0; k < 10; k++) begin
      t = int'($urandom_range(0, 15));
      d = int'($urandom_range(0, 3));
      do_txn(t, d, 1'b0, 0, 0);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
    end

    // Reset asserted mid-ramp returns outputs immediately.
    tgt_valid = 1'b1;
    tgt_duty  = (m_duty < 8) ? DUTY_W'(15) : DUTY_W'(0);
    step_div  = DIV_W'(1);
    @(posedge clk); #1;
    tgt_valid = 1'b0;
    repeat (3 * PERIOD) @(posedge clk);
    #1;
    chk("midramp_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midramp_rst");
    @(negedge clk) reset_n = 1'b1;
    m_duty = 0;
    do_txn(3, 2, 1'b0, 0, 0);

`ifdef PWM_RAMP_BREATHE_EN
    begin
      int seq [10];
      seq = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3};
      do_txn(0, 1, 1'b0, 0, 0);
      breathe_en = 1'b1;
      tgt_valid  = 1'b1;
      tgt_duty   = DUTY_W'(3);
      step_div   = DIV_W'(1);
      @(posedge clk); #1;
      tgt_valid = 1'b0;
      for (int k = 1; k < 10; k++) begin
        wait_boundary("brth_boundary");
        chk("brth_duty", duty_cycle, seq[k]);
        chk("brth_done", done, (seq[k] == 0 || seq[k] == 3) ? 1 : 0);
        chk("brth_ready", tgt_ready, (k == 9) ? 1 : 0);
        if (k == 7) breathe_en = 1'b0;
      end
      @(posedge clk); #1;
      chk("brth_end_busy", busy, 0);
      chk("brth_end_duty", duty_cycle, 3);
      m_duty = 3;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
